// File: rtl/custom_stage_reorder.sv
// Stage-to-address reorder buffer: collects one 25-word frame in stage order
// and replays it in ascending memory-address order for the linear SRAM writer.
module custom_stage_reorder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              frame_err
);

    localparam int unsigned FRAME_LEN = 25;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(FRAME_LEN - 2);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_addr;
    logic [DATA_W-1:0]  mem [FRAME_LEN];

    // Address -> stage that produced the word destined for that address.
    function automatic logic [CNT_W-1:0] inv(input logic [CNT_W-1:0] addr);
        logic [CNT_W-1:0] cnt;
        case (int'(addr))
            0, 1, 2, 3:          cnt = addr;
            4:                   cnt = CNT_W'(10);
            5:                   cnt = CNT_W'(12);
            6:                   cnt = CNT_W'(14);
            7:                   cnt = CNT_W'(17);
            8:                   cnt = CNT_W'(19);
            9:                   cnt = CNT_W'(4);
            10:                  cnt = CNT_W'(5);
            11:                  cnt = CNT_W'(6);
            12:                  cnt = CNT_W'(7);
            13:                  cnt = CNT_W'(8);
            14:                  cnt = CNT_W'(9);
            15:                  cnt = CNT_W'(11);
            16:                  cnt = CNT_W'(13);
            17:                  cnt = CNT_W'(15);
            18:                  cnt = CNT_W'(16);
            19:                  cnt = CNT_W'(18);
            20, 21, 22, 23, 24:  cnt = addr;
            default:             cnt = '0;
        endcase
        return cnt;
    endfunction

    // Frame storage; every entry is rewritten before it is read, so no reset.
    always_ff @(posedge clk) begin
        if (state == FILL && in_valid) begin
            mem[wr_cnt] <= in_data;
        end
    end

    // Control FSM with registered handshake, last and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_addr   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        if (in_last != (wr_cnt == LAST_IDX)) begin
                            frame_err <= 1'b1;
                        end
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt    <= '0;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_addr == LAST_IDX) begin
                            rd_addr   <= '0;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_addr  <= rd_addr + CNT_W'(1);
                            out_last <= (rd_addr == PRE_LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign out_addr = ADDR_W'(rd_addr);
    assign out_data = out_valid ? mem[inv(rd_addr)] : '0;

endmodule
